uart_tx_fifo_param: RTL and testbench
=====================================

# uart_tx_fifo_param

Parametrised, buffered UART transmitter: accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `tx`. Frame format is fixed at elaboration: data width, optional parity (odd or even), and 1 or 2 stop bits. It sits between the register/stream side of the design and the UART pin. It replaces the single-shot fixed-8N1 transmitter with back-to-back frames, no idle gap.

## Interface
- `CLK_DIV`, default 16: clocks per bit; legal values ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, default 4: FIFO entries; power of 2, ≥ 2.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `s_valid`, input, 1: write request.
- `s_data`, input, `DATA_BITS`: word to send.
- `s_ready`, output, 1: FIFO not full; a word is accepted on a rising edge where `s_valid && s_ready`.
- `tx`, output, 1: serial line, registered; idles high.
- `busy`, output, 1: serialiser is not in IDLE.
- `tx_done`, output, 1: one-cycle pulse after the final stop bit of each frame.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_count`=0, `s_ready`=1. The FIFO is emptied and the serialiser returns to IDLE.
- `s_ready` = !full, combinational from the occupancy register.
- Push and pop in the same cycle are legal; `fifo_count` is then unchanged.
- When full, `s_valid` is ignored and no data is overwritten.
- Serialiser FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The head word is popped into the shift register on the same edge.
  - START → DATA after 1 bit time.
  - DATA → PARITY after `DATA_BITS` bit times if `PARITY_EN`=1; otherwise DATA → STOP.
  - PARITY → STOP after 1 bit time.
  - STOP ends after `STOP_BITS` bit times. It then goes to START if the FIFO is non-empty (pop on the same edge), otherwise to IDLE.
- Line levels: START drives `tx`=0. DATA drives data LSB-first. PARITY drives the XOR of the data bits for even parity, or its inverse for odd. STOP and IDLE drive `tx`=1.
- Baud counter: width $clog2(CLK_DIV), counts 0..CLK_DIV-1, reloads 0 on every bit boundary. Every bit is exactly `CLK_DIV` cycles.
- Bit counter: counts data bits and stop bits; width is sized for max(DATA_BITS, STOP_BITS).
- Frame length in cycles: `CLK_DIV` × (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`).
- `tx_done` is asserted for one cycle, registered, on the edge that leaves STOP. This holds whether the next state is IDLE or START.
- The word is captured at pop. Later FIFO writes never alter a frame in flight.

## Timing
- Latency: a word accepted at edge N into an empty FIFO with the serialiser in IDLE is popped at edge N+1. `tx` falls at edge N+1 and the start bit lasts `CLK_DIV` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle. There are zero idle cycles.
- `busy` is 1 from the edge entering START until the edge returning to IDLE.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). No `tx_done` is generated and the partial frame is discarded.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants;
  - a function computing bits-per-frame from the parameters.
- Sub-module `uart_sync_fifo`: parametrised width/depth, synchronous read, asynchronous active-high reset, with full/empty/count outputs.
- The top level holds the FSM, baud counter, bit counter, shift register and parity generator.

## Test plan
1. `CLK_DIV`=4, 8N1, one write of 0xA5:
   - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles, `tx` falling 1 cycle after the accept edge;
   - `tx_done` pulses 40 cycles after `tx` falls;
   - `busy` is high for exactly 40 cycles.
2. `PARITY_EN`=1, even parity, write 0x07: parity bit = 1. Repeat with `PARITY_ODD`=1: parity bit = 0. Repeat with 0x00, even parity: parity bit = 0.
3. `STOP_BITS`=2, `DATA_BITS`=5, write 0x1F: frame is 8 bit times (32 cycles at `CLK_DIV`=4), with stop high for 8 cycles.
4. Burst of 5 writes, `FIFO_DEPTH`=4, `s_valid` held high:
   - `s_ready` drops while the FIFO is full, and no word is lost or duplicated;
   - frames are contiguous with no idle cycle between the stop bit and the next start bit;
   - `tx_done` pulses 5 times.
5. Simultaneous push and pop while `fifo_count`=2: `fifo_count` stays 2.
6. Assert `reset` mid-DATA:
   - `tx` is 1 and `busy`, `tx_done` and `fifo_count` are 0 in the same cycle;
   - after release, a new write of 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    // Serialiser states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Parity-mode encodings for the PARITY_ODD parameter.
    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    // Number of bit times in one frame: start + data + optional parity + stop.
    function automatic int uart_frame_bits(input int data_bits,
                                           input int parity_en,
                                           input int stop_bits);
        return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO. The head entry is always presented on rd_data so
// the consumer can capture it on the same edge that pops it.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO drops writes; an empty one ignores reads.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next-state pointers and occupancy; push+pop together leave count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array is left unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: FIFO in front of a frame serialiser with
// elaboration-time data width, parity and stop-bit count.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int   BAUD_W  = $clog2(CLK_DIV);
    localparam int   BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int   BIT_W   = $clog2(BIT_MAX);
    localparam logic PAR_INV = (PARITY_ODD == PARITY_MODE_ODD);

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 head_par;
    logic                 bit_end;

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s_valid),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign s_ready  = !fifo_full;
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign bit_end  = (baud_q == BAUD_W'(CLK_DIV - 1));
    // Parity is computed from the word at pop time since the shifter consumes it.
    assign head_par = (^fifo_head) ^ PAR_INV;

    // Frame sequencing, baud/bit counting and the registered line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        tx_d    = 1'b1;

        if (state_q != ST_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    par_d   = head_par;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next frame with no idle gap.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            par_d   = head_par;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so tx is a clean register.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // Serialiser registers; reset forces the line high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param across four frame configurations.
module tb_uart_tx_fifo_param;

    logic       clk;
    logic       reset;
    logic       s_valid_r [4];
    logic [7:0] s_data_r  [4];
    logic       rdy_w     [4];
    logic       tx_w      [4];
    logic       busy_w    [4];
    logic       done_w    [4];
    logic [2:0] cnt_w     [4];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2 -- all CLK_DIV=4, depth 4
    uart_tx_fifo_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .s_valid(s_valid_r[0]), .s_data(s_data_r[0]),
        .s_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]),
        .fifo_count(cnt_w[0]));

    uart_tx_fifo_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
        .clk(clk), .reset(reset), .s_valid(s_valid_r[1]), .s_data(s_data_r[1]),
        .s_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]),
        .fifo_count(cnt_w[1]));

    uart_tx_fifo_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .reset(reset), .s_valid(s_valid_r[2]), .s_data(s_data_r[2]),
        .s_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]),
        .fifo_count(cnt_w[2]));

    uart_tx_fifo_param #(.CLK_DIV(4), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0),
                         .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .reset(reset), .s_valid(s_valid_r[3]), .s_data(s_data_r[3][4:0]),
        .s_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]),
        .fifo_count(cnt_w[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write one word into an idle DUT and follow its whole frame cycle by cycle.
    task automatic send_frame(input int d, input logic [7:0] data, input int nbits,
                              input logic [15:0] frame, input string tag);
        @(negedge clk);
        s_valid_r[d] = 1'b1;
        s_data_r[d]  = data;
        @(posedge clk); #1;
        s_valid_r[d] = 1'b0;
        check_eq({tag, "/accept_cnt"}, cnt_w[d], 1);
        check_eq({tag, "/accept_busy"}, busy_w[d], 0);
        check_eq({tag, "/accept_tx"}, tx_w[d], 1);
        for (int i = 0; i < nbits * 4; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("%s/tx[%0d]", tag, i), tx_w[d], frame[i/4]);
            check_eq($sformatf("%s/busy[%0d]", tag, i), busy_w[d], 1);
            check_eq($sformatf("%s/done[%0d]", tag, i), done_w[d], 0);
        end
        @(posedge clk); #1;
        check_eq({tag, "/done_pulse"}, done_w[d], 1);
        check_eq({tag, "/busy_end"}, busy_w[d], 0);
        check_eq({tag, "/tx_idle"}, tx_w[d], 1);
        check_eq({tag, "/cnt_end"}, cnt_w[d], 0);
        @(posedge clk); #1;
        check_eq({tag, "/done_clear"}, done_w[d], 0);
        $display("frame %s data=%02h bits=%0d checked", tag, data, nbits);
    endtask

    initial begin
        logic [7:0] words [5];
        logic [9:0] fr;
        int         sent;
        int         ndone;

        for (int k = 0; k < 4; k++) begin
            s_valid_r[k] = 1'b0;
            s_data_r[k]  = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/tx", tx_w[0], 1);
        check_eq("rst/busy", busy_w[0], 0);
        check_eq("rst/done", done_w[0], 0);
        check_eq("rst/cnt", cnt_w[0], 0);
        check_eq("rst/ready", rdy_w[0], 1);
        @(negedge clk);
        reset = 1'b0;

        // 8N1 0xA5: start, A5 LSB-first, stop
        send_frame(0, 8'hA5, 10, 16'(10'b1_10100101_0), "t1_A5");
        // 8E1 0x07 -> parity 1; 8O1 0x07 -> parity 0; 8E1 0x00 -> parity 0
        send_frame(1, 8'h07, 11, 16'(11'b1_1_00000111_0), "t2_even07");
        send_frame(2, 8'h07, 11, 16'(11'b1_0_00000111_0), "t2_odd07");
        send_frame(1, 8'h00, 11, 16'(11'b1_0_00000000_0), "t2_even00");
        // 5N2 0x1F: 8 bit times, stop high for 8 cycles
        send_frame(3, 8'h1F, 8, 16'(8'b11_11111_0), "t3_5n2");

        // Burst of 5 with valid held; extra cycles while full must be ignored.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        sent  = 0;
        ndone = 0;
        for (int t = 1; t <= 205; t++) begin
            @(negedge clk);
            s_valid_r[0] = (t <= 7);
            s_data_r[0]  = (sent < 5) ? words[sent] : 8'h66;
            if (s_valid_r[0] && rdy_w[0]) sent++;
            @(posedge clk); #1;
            if (t == 5) begin
                check_eq("t4/ready_full", rdy_w[0], 0);
                check_eq("t4/cnt_full", cnt_w[0], 4);
            end
            if (t == 7) check_eq("t4/cnt_hold", cnt_w[0], 4);
            if (t >= 2 && t <= 201) begin
                fr = {1'b1, words[(t-2)/40], 1'b0};
                check_eq($sformatf("t4/tx@%0d", t), tx_w[0], fr[((t-2)%40)/4]);
                check_eq($sformatf("t4/busy@%0d", t), busy_w[0], 1);
            end else if (t > 201) begin
                check_eq($sformatf("t4/tx_idle@%0d", t), tx_w[0], 1);
            end
            if (done_w[0]) begin
                check_eq($sformatf("t4/done_time%0d", ndone), t, 42 + 40 * ndone);
                ndone++;
            end
        end
        s_valid_r[0] = 1'b0;
        check_eq("t4/accepted", sent, 5);
        check_eq("t4/done_count", ndone, 5);
        check_eq("t4/busy_end", busy_w[0], 0);
        check_eq("t4/cnt_end", cnt_w[0], 0);
        $display("burst 5 words checked, done pulses=%0d", ndone);

        // Push coinciding with the frame-end pop while two words are queued.
        ndone = 0;
        for (int t = 1; t <= 170; t++) begin
            @(negedge clk);
            s_valid_r[0] = (t <= 3) || (t == 42);
            s_data_r[0]  = (t == 1) ? 8'hA1 : (t == 2) ? 8'hB2 : (t == 3) ? 8'hC3 : 8'hD4;
            @(posedge clk); #1;
            if (t == 3)  check_eq("t5/cnt_before", cnt_w[0], 2);
            if (t == 41) check_eq("t5/cnt_pre", cnt_w[0], 2);
            if (t == 42) begin
                check_eq("t5/cnt_pushpop", cnt_w[0], 2);
                check_eq("t5/done_at_pop", done_w[0], 1);
                check_eq("t5/next_start", tx_w[0], 0);
            end
            if (t == 43) check_eq("t5/cnt_after", cnt_w[0], 2);
            if (done_w[0]) ndone++;
        end
        s_valid_r[0] = 1'b0;
        check_eq("t5/done_count", ndone, 4);
        check_eq("t5/busy_end", busy_w[0], 0);
        $display("push/pop at count 2 checked, frames=%0d", ndone);

        // Reset asserted in the middle of the data bits.
        @(negedge clk);
        s_valid_r[0] = 1'b1;
        s_data_r[0]  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        s_data_r[0]  = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        s_valid_r[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check_eq("t6/pre_busy", busy_w[0], 1);
        check_eq("t6/pre_cnt", cnt_w[0], 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6/rst_tx", tx_w[0], 1);
        check_eq("t6/rst_busy", busy_w[0], 0);
        check_eq("t6/rst_done", done_w[0], 0);
        check_eq("t6/rst_cnt", cnt_w[0], 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("t6/quiet_done%0d", i), done_w[0], 0);
            check_eq($sformatf("t6/quiet_tx%0d", i), tx_w[0], 1);
        end
        send_frame(0, 8'h3C, 10, 16'(10'b1_00111100_0), "t6_3C");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
